// File: rtl/onehot_arb2.sv
// ---------------------------------------------------------------------------
// onehot_arb2 -- two-requester round-robin arbiter with a registered output.
//
// The two requesters offer payloads with valid/ready handshakes. The winner is
// moved through a one-hot AND-OR mux into a single output register. That
// register is refilled in the same cycle it drains, so the block can complete
// one transfer per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req0_valid  requester 0 offers req0_data
//   req0_data   requester 0 payload (WIDTH bits)
//   req0_ready  requester 0 payload taken this cycle (== sel[0])
//   req1_valid  requester 1 offers req1_data
//   req1_data   requester 1 payload (WIDTH bits)
//   req1_ready  requester 1 payload taken this cycle (== sel[1])
//   out_valid   output register holds a payload
//   out_data    registered payload
//   out_src     index of the requester that supplied out_data
//   out_ready   consumer takes out_data this cycle
//   sel         one-hot grant for this cycle, 2'b00 when nothing is granted
//   prio        index of the requester that wins the next tie
// ---------------------------------------------------------------------------
module onehot_arb2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             prio
);

    logic             load_en;
    logic             grant;
    logic [WIDTH-1:0] sel_data;

    // The output register may take new data when it is empty, or when its
    // current content leaves this cycle.
    assign load_en = !out_valid || out_ready;

    // The grant is also forced off during reset, so no requester sees a
    // handshake while the block is held in reset.
    always_comb begin
        sel = 2'b00;
        if (!rst && load_en) begin
            case ({req1_valid, req0_valid})
                2'b01:   sel = 2'b01;
                2'b10:   sel = 2'b10;
                2'b11:   sel = prio ? 2'b10 : 2'b01;
                default: sel = 2'b00;
            endcase
        end
    end

    assign req0_ready = sel[0];
    assign req1_ready = sel[1];
    assign grant      = sel[0] | sel[1];

    // sel is one-hot or zero, so an AND-OR mux is enough. With no grant the
    // mux output is zero, and that value is never loaded.
    assign sel_data = ({WIDTH{sel[0]}} & req0_data)
                    | ({WIDTH{sel[1]}} & req1_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            prio      <= 1'b0;
        end else if (load_en) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= sel[1];
                // The requester that just won yields the next tie.
                prio      <= ~sel[1];
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_arb2.sv
// ---------------------------------------------------------------------------
// tb_onehot_arb2 -- scoreboard bench for onehot_arb2.
//
// A driver applies directed and random traffic. For each cycle it predicts the
// grant from the arbitration rules. Each predicted acceptance pushes an
// {data, src} entry into a queue. A separate monitor pops one entry whenever
// the DUT hands a payload to the consumer and compares the two.
// ---------------------------------------------------------------------------
module tb_onehot_arb2;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_src;
    logic          out_ready;
    logic [1:0]    sel;
    logic          prio;

    onehot_arb2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .sel        (sel),
        .prio       (prio)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    exp_t q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Abstract model state: is the output slot occupied, and who wins the
    // next tie.
    logic m_full;
    logic m_prio;
    int   wait_cnt [2];

    // DUT values captured at the mid-cycle sample of the latest step.
    logic [1:0]   cap_sel;
    logic [W-1:0] cap_data;
    logic         cap_src;
    logic         cap_valid;
    logic         cap_prio;
    logic [1:0]   last_grant;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a payload leaves the DUT when out_valid and out_ready are both
    // high. It must match the oldest predicted acceptance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got data %0h src %0d, expected none", out_data, out_src);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_src", {31'b0, out_src}, {31'b0, e.s});
                end
            end
        end
    end

    // One clock cycle. Entered just after a rising edge; it returns just
    // after the next rising edge.
    task automatic step(input logic v0, input logic [W-1:0] d0,
                        input logic v1, input logic [W-1:0] d1,
                        input logic ordy);
        logic       can_load;
        logic [1:0] es;
        logic [1:0] vv;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        out_ready  = ordy;
        @(negedge clk);
        can_load = !m_full || ordy;
        es = 2'b00;
        if (can_load) begin
            if (v0 && v1) es = m_prio ? 2'b10 : 2'b01;
            else if (v0)  es = 2'b01;
            else if (v1)  es = 2'b10;
        end
        chk("sel", {30'b0, sel}, {30'b0, es});
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, es[0]});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, es[1]});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
        chk("prio", {31'b0, prio}, {31'b0, m_prio});
        cap_sel = sel; cap_data = out_data; cap_src = out_src;
        cap_valid = out_valid; cap_prio = prio;
        // Fairness: a waiting requester may be passed over at most once
        // across cycles in which the output can load.
        vv = {v1, v0};
        if (can_load) begin
            for (int i = 0; i < 2; i++) begin
                if (vv[i]) begin
                    if (es[i]) begin
                        chk($sformatf("starve_wait%0d", i), wait_cnt[i], 0 + (wait_cnt[i] > 1 ? 1 : wait_cnt[i]));
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                    end
                end
            end
        end
        if (es != 2'b00) q.push_back('{d: (es[1] ? d1 : d0), s: es[1]});
        @(posedge clk);
        if (can_load) begin
            if (es != 2'b00) begin
                m_full = 1'b1;
                m_prio = ~es[1];
            end else begin
                m_full = 1'b0;
            end
        end
        last_grant = es;
        #1;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_prio = 1'b0;
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        q.delete();
    endtask

    initial begin
        logic         p0, p1;
        logic [W-1:0] r0, r1;
        logic         ordy;

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'hDEAD_0000; req1_data = 32'hDEAD_0001;
        out_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", {31'b0, out_src}, 0);
        chk("rst_prio", {31'b0, prio}, 0);
        chk("rst_sel", {30'b0, sel}, 0);
        chk("rst_readys", {30'b0, req1_ready, req0_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Tie every cycle: the grant alternates starting at requester 0.
        step(1, 32'hA0, 1, 32'hB1, 1); chk("rr_sel0", {30'b0, cap_sel}, 2'b01);
        step(1, 32'hA0, 1, 32'hB1, 1); chk("rr_sel1", {30'b0, cap_sel}, 2'b10);
        chk("rr_data0", cap_data, 32'hA0); chk("rr_src0", {31'b0, cap_src}, 0);
        step(1, 32'hA0, 1, 32'hB1, 1); chk("rr_sel2", {30'b0, cap_sel}, 2'b01);
        chk("rr_data1", cap_data, 32'hB1); chk("rr_src1", {31'b0, cap_src}, 1);
        step(1, 32'hA0, 1, 32'hB1, 1); chk("rr_sel3", {30'b0, cap_sel}, 2'b10);
        chk("rr_data2", cap_data, 32'hA0);
        step(0, 0, 0, 0, 0);
        chk("rr_data3", cap_data, 32'hB1); chk("rr_src3", {31'b0, cap_src}, 1);
        step(0, 0, 0, 0, 1);

        // A stalled consumer: one accept, then the output is held.
        step(1, 32'h55, 0, 0, 0); chk("stall_acc", {30'b0, cap_sel}, 2'b01);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 32'h77, 0);
            chk("stall_sel", {30'b0, cap_sel}, 2'b00);
            chk("stall_data", cap_data, 32'h55);
            chk("stall_valid", {31'b0, cap_valid}, 1);
        end
        // Drain and refill in the same cycle, with no bubble.
        step(0, 0, 1, 32'h77, 1); chk("refill_sel", {30'b0, cap_sel}, 2'b10);
        step(0, 0, 0, 0, 0);
        chk("refill_valid", {31'b0, cap_valid}, 1);
        chk("refill_data", cap_data, 32'h77);
        chk("refill_src", {31'b0, cap_src}, 1);

        // Single-requester grants also move the pointer.
        for (int k = 0; k < 3; k++) step(0, 0, 1, 32'h100 + k, 1);
        step(1, 32'h200, 1, 32'h201, 1);
        chk("single_prio", {31'b0, cap_prio}, 0);
        chk("single_tie", {30'b0, cap_sel}, 2'b01);
        step(0, 0, 1, 32'hCC, 1);
        step(0, 0, 0, 0, 0);

        // Asynchronous reset between edges while the output is full.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_out_src", {31'b0, out_src}, 0);
        chk("arst_prio", {31'b0, prio}, 0);
        chk("arst_sel", {30'b0, sel}, 0);
        chk("arst_readys", {30'b0, req1_ready, req0_ready}, 0);
        model_reset();
        @(posedge clk); @(posedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        step(1, 32'hE0, 1, 32'hE1, 1); chk("post_rst_sel", {30'b0, cap_sel}, 2'b01);
        step(0, 0, 1, 32'hE1, 1);

        // Random traffic. A requester holds its request until it is accepted.
        p0 = 1'b0; p1 = 1'b0; r0 = '0; r1 = '0;
        for (int n = 0; n < 10000; n++) begin
            if (!p0 && $urandom_range(99) < 60) begin p0 = 1'b1; r0 = $urandom; end
            if (!p1 && $urandom_range(99) < 60) begin p1 = 1'b1; r1 = $urandom; end
            ordy = ($urandom_range(99) < 70);
            step(p0, r0, p1, r1, ordy);
            if (last_grant[0]) p0 = 1'b0;
            if (last_grant[1]) p1 = 1'b0;
        end
        if (p0 || p1) step(p0, r0, p1, r1, 1);
        if (p0 || p1) step(p0 & ~last_grant[0], r0, p1 & ~last_grant[1], r1, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
